i2c_master_controller: RTL

//  Single-master I2C controller: the initiator end of the bus served by SlaveController.
//  - Takes one command (7-bit address, R/W, byte count) and generates START, address, data, ACK/NACK and STOP.
//  - Derives SCL from the system clock.
//  - Drives SDA open-drain style via sda_out/sda_out_en; samples sda_in.
//  - Sits between the host register file and the bus pads; no clock stretching, no arbitration.

---
 rtl/i2c_master_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_controller.sv
// Single-master I2C controller: START, address byte, data/ACK slots and STOP, with SCL derived from clk.
// Every bit slot is four CLK_DIV-cycle phases A/B (SCL low) and C/D (SCL high); SDA is sampled at the end of C.
module i2c_master_controller #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_start,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_len,
  input  logic [7:0] txdata,
  output logic       tx_ready,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       nack_error,
  output logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_out_en
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    ph_q;
  logic [2:0]    bit_q;
  logic [7:0]    txb_q, len_q, rxsh_q, rxdata_q;
  logic          rw_q, samp_q;
  logic          scl_q, sda_en_q, tx_ready_q, rx_valid_q, busy_q, done_q, nack_q;
  logic          cnt_end;
  logic [2:0]    last_ph;

  assign cnt_end = (cnt_q == CW'(CLK_DIV - 1));

  // START holds two phases; STOP adds two bus-free phases after its four bit phases
  always_comb begin
    last_ph = 3'd3;
    if (state_q == START)     last_ph = 3'd1;
    else if (state_q == STOP) last_ph = 3'd5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      bit_q      <= '0;
      txb_q      <= '0;
      len_q      <= '0;
      rxsh_q     <= '0;
      rxdata_q   <= '0;
      rw_q       <= 1'b0;
      samp_q     <= 1'b1;
      scl_q      <= 1'b1;
      sda_en_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (state_q == IDLE) begin
        if (cmd_start && !done_q) begin
          txb_q    <= {cmd_addr, cmd_rw};
          rw_q     <= cmd_rw;
          len_q    <= cmd_len;
          nack_q   <= 1'b0;
          busy_q   <= 1'b1;
          sda_en_q <= 1'b1;
          cnt_q    <= '0;
          ph_q     <= '0;
          state_q  <= START;
        end
      end else begin
        // write byte bit 7 goes out once txdata is captured, still inside SCL-low phase A/B
        if (state_q == WRITE && tx_ready_q) begin
          txb_q    <= txdata;
          sda_en_q <= ~txdata[7];
        end
        if (cnt_end && ph_q == 3'd2) begin
          samp_q <= sda_in;
          rxsh_q <= {rxsh_q[6:0], sda_in};
          if (state_q == READ && bit_q == 3'd0) begin
            rxdata_q   <= {rxsh_q[6:0], sda_in};
            rx_valid_q <= 1'b1;
          end
        end
        if (!cnt_end) begin
          cnt_q <= cnt_q + CW'(1);
        end else begin
          cnt_q <= '0;
          if (ph_q != last_ph) begin
            ph_q <= ph_q + 3'd1;
            if (ph_q == 3'd1 && state_q != START) scl_q <= 1'b1;
            if (state_q == STOP && ph_q == 3'd3) sda_en_q <= 1'b0;
          end else begin
            ph_q  <= '0;
            scl_q <= 1'b0;
            case (state_q)
              START: begin
                state_q  <= ADDR;
                bit_q    <= 3'd7;
                sda_en_q <= ~txb_q[7];
              end
              ADDR, WRITE: begin
                if (bit_q == 3'd0) begin
                  state_q  <= (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                  sda_en_q <= 1'b0;
                end else begin
                  bit_q    <= bit_q - 3'd1;
                  sda_en_q <= ~txb_q[bit_q - 3'd1];
                end
              end
              ADDR_ACK: begin
                bit_q <= 3'd7;
                if (samp_q || len_q == 8'd0) begin
                  nack_q   <= samp_q;
                  state_q  <= STOP;
                  sda_en_q <= 1'b1;
                end else if (rw_q) begin
                  state_q  <= READ;
                  sda_en_q <= 1'b0;
                end else begin
                  state_q    <= WRITE;
                  tx_ready_q <= 1'b1;
                  sda_en_q   <= 1'b0;
                end
              end
              WR_ACK: begin
                bit_q <= 3'd7;
                if (samp_q) begin
                  nack_q   <= 1'b1;
                  state_q  <= STOP;
                  sda_en_q <= 1'b1;
                end else begin
                  len_q <= len_q - 8'd1;
                  if (len_q == 8'd1) begin
                    state_q  <= STOP;
                    sda_en_q <= 1'b1;
                  end else begin
                    state_q    <= WRITE;
                    tx_ready_q <= 1'b1;
                    sda_en_q   <= 1'b0;
                  end
                end
              end
              READ: begin
                sda_en_q <= 1'b0;
                if (bit_q == 3'd0) begin
                  state_q  <= RD_ACK;
                  sda_en_q <= (len_q != 8'd1);
                end else begin
                  bit_q <= bit_q - 3'd1;
                end
              end
              RD_ACK: begin
                bit_q <= 3'd7;
                len_q <= len_q - 8'd1;
                if (len_q == 8'd1) begin
                  state_q  <= STOP;
                  sda_en_q <= 1'b1;
                end else begin
                  state_q  <= READ;
                  sda_en_q <= 1'b0;
                end
              end
              STOP: begin
                scl_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign rxdata     = rxdata_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack_error = nack_q;
  assign scl        = scl_q;
  assign sda_out    = ~sda_en_q;
  assign sda_out_en = sda_en_q;

endmodule
